// File: rtl/b11_sym_feeder_if.sv
// Bundle between the b11 symbol feeder and its neighbours: serial stream and
// pacing enable in, b11 symbol/strobe and FIFO status out.
interface b11_sym_feeder_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic          ser_in;
  logic          ser_valid;
  logic          ser_sync;
  logic          enable;
  logic [5:0]    x_in;
  logic          stbi;
  logic [LW-1:0] fifo_level;
  logic          overflow;

  modport master (
    output ser_in, ser_valid, ser_sync, enable,
    input  x_in, stbi, fifo_level, overflow
  );

  modport slave (
    input  ser_in, ser_valid, ser_sync, enable,
    output x_in, stbi, fifo_level, overflow
  );
endinterface

// File: rtl/b11_sym_feeder.sv
// Upstream feeder for b11: deserialises LSB-first 6-bit symbols into a FIFO and
// strobes them out on x_in/stbi with an enforced hold gap between strobes.
module b11_sym_feeder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned GAP   = 32
) (
  input logic             clock,
  input logic             reset,
  b11_sym_feeder_if.slave bus
);
  localparam int unsigned   PW       = $clog2(DEPTH);
  localparam int unsigned   LW       = $clog2(DEPTH) + 1;
  localparam int unsigned   GW       = $clog2(GAP + 1);
  localparam logic [LW-1:0] LevelMax = LW'(DEPTH);
  localparam logic [GW-1:0] GapLoad  = GW'(GAP - 1);
  localparam logic [GW-1:0] GapOne   = GW'(1);

  typedef enum logic [1:0] {StIdle, StStrobe, StHold} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;

  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [5:0]    shreg_q, shreg_d;
  logic          sym_done;

  logic [5:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q;
  logic          push_ok;
  logic          start;

  logic [5:0]    x_in_q, x_in_d;
  logic          stbi_q, stbi_d;

  // Deserialiser: sync wins over an in-flight symbol, but its own bit counts as bit0.
  always_comb begin
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    sym_done = 1'b0;
    if (bus.ser_sync) begin
      shreg_d  = {5'd0, bus.ser_in & bus.ser_valid};
      bitcnt_d = bus.ser_valid ? 3'd1 : 3'd0;
    end else if (bus.ser_valid) begin
      for (int i = 0; i < 6; i++) begin
        if (bitcnt_q == 3'(i)) shreg_d[i] = bus.ser_in;
      end
      if (bitcnt_q == 3'd5) begin
        sym_done = 1'b1;
        bitcnt_d = 3'd0;
      end else begin
        bitcnt_d = bitcnt_q + 3'd1;
      end
    end
  end

  // Pop decision uses the registered level, so a fresh symbol never bypasses the FIFO.
  assign start   = (state_q == StIdle) && bus.enable && (level_q != '0);
  assign push_ok = sym_done && ((level_q != LevelMax) || start);

  always_comb begin
    level_d = level_q;
    unique case ({push_ok, start})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= shreg_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bitcnt_q   <= 3'd0;
      shreg_q    <= 6'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      level_q  <= level_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (start) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (sym_done && !push_ok) overflow_q <= 1'b1;
    end
  end

  // Output FSM: state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // Output FSM: next state. HOLD leaves on the edge the counter reaches zero.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StStrobe;
      end
      StStrobe: begin
        state_d = (GAP > 1) ? StHold : StIdle;
        gap_d   = GapLoad;
      end
      StHold: begin
        if (gap_q <= GapOne) begin
          state_d = StIdle;
          gap_d   = '0;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        gap_d   = '0;
      end
    endcase
  end

  // Output FSM: registered outputs; x_in only changes on a strobe.
  always_comb begin
    stbi_d = 1'b1;
    x_in_d = x_in_q;
    if (start) begin
      stbi_d = 1'b0;
      x_in_d = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_in_q <= 6'd0;
      stbi_q <= 1'b1;
    end else begin
      x_in_q <= x_in_d;
      stbi_q <= stbi_d;
    end
  end

  assign bus.x_in       = x_in_q;
  assign bus.stbi       = stbi_q;
  assign bus.fifo_level = level_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_b11_sym_feeder.sv
// Scoreboard bench for b11_sym_feeder: a queue-level reference model predicts
// each strobe (symbol and cycle); a negedge monitor checks the DUT against it.
module tb_b11_sym_feeder;
  localparam int DEPTH = 4;
  localparam int GAP   = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;

  b11_sym_feeder_if #(.DEPTH(DEPTH)) bus ();

  b11_sym_feeder #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0] sym;
    int         cyc;
  } exp_t;

  int total = 0;
  int bad   = 0;

  logic [5:0] m_q[$];
  exp_t       exp_q[$];
  bit   [5:0] m_bits;
  int         m_n;
  bit         m_ovf;
  int         cyc;
  int         next_ok;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: symbols as a queue, pacing as "earliest cycle of next strobe".
  always @(posedge clock or negedge reset) begin
    exp_t e;
    if (!reset) begin
      m_q.delete();
      exp_q.delete();
      m_bits  = '0;
      m_n     = 0;
      m_ovf   = 1'b0;
      cyc     = 0;
      next_ok = 0;
    end else begin
      cyc++;
      if (bus.enable && m_q.size() > 0 && cyc >= next_ok) begin
        e.sym   = m_q.pop_front();
        e.cyc   = cyc;
        exp_q.push_back(e);
        next_ok = cyc + GAP + 1;
      end
      if (bus.ser_sync) begin
        m_bits = '0;
        m_n    = 0;
        if (bus.ser_valid) begin
          m_bits[0] = bus.ser_in;
          m_n       = 1;
        end
      end else if (bus.ser_valid) begin
        m_bits[m_n] = bus.ser_in;
        m_n++;
        if (m_n == 6) begin
          if (m_q.size() < DEPTH) m_q.push_back(m_bits);
          else m_ovf = 1'b1;
          m_n = 0;
        end
      end
    end
  end

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      if (bus.stbi == 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_x_in", int'(bus.x_in), int'(e.sym));
          chk("strobe_cycle", cyc, e.cyc);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("missing_strobe_cycle", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      chk("fifo_level", int'(bus.fifo_level), m_q.size());
      chk("overflow", int'(bus.overflow), int'(m_ovf));
    end
  end

  task automatic step(input bit v, input bit b, input bit s);
    bus.ser_valid = v;
    bus.ser_in    = b;
    bus.ser_sync  = s;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_sym(input logic [5:0] v);
    for (int i = 0; i < 6; i++) step(1'b1, v[i], 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x_in"}, int'(bus.x_in), 0);
    chk({tag, "_stbi"}, int'(bus.stbi), 1);
    chk({tag, "_level"}, int'(bus.fifo_level), 0);
    chk({tag, "_overflow"}, int'(bus.overflow), 0);
  endtask

  initial begin
    logic [5:0] v;
    bus.ser_in    = 1'b0;
    bus.ser_valid = 1'b0;
    bus.ser_sync  = 1'b0;
    bus.enable    = 1'b0;
    #2 reset = 1'b0;
    #1 chk_reset_vals("reset");
    @(negedge clock);
    @(negedge clock);
    reset      = 1'b1;
    bus.enable = 1'b1;

    // Bits 1,0,1,1,0,0 -> 13.
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
    step(1, 1, 0); step(1, 0, 0); step(1, 0, 0);
    chk("first_sym_level", int'(bus.fifo_level), 1);
    idle(40);

    // Back-to-back symbols.
    send_sym(6'd0);
    send_sym(6'd63);
    send_sym(6'd26);
    idle(3 * (GAP + 1) + 10);

    // Overflow with enable low, then drain.
    bus.enable = 1'b0;
    for (int i = 0; i < 5; i++) send_sym(6'(10 + i));
    chk("sat_level", int'(bus.fifo_level), DEPTH);
    chk("sat_overflow", int'(bus.overflow), 1);
    bus.enable = 1'b1;
    idle(DEPTH * (GAP + 1) + 10);
    chk("overflow_sticky", int'(bus.overflow), 1);

    // Sync mid-symbol: partial bits discarded, sync bit becomes bit0 -> 1.
    step(1, 1, 0); step(1, 1, 0); step(1, 0, 0);
    step(1, 1, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    idle(GAP + 5);

    // Reset during HOLD with two symbols queued.
    send_sym(6'd7);
    send_sym(6'd44);
    send_sym(6'd21);
    chk("pre_reset_level", int'(bus.fifo_level), 2);
    #2 reset = 1'b0;
    #1 chk_reset_vals("async_reset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    idle(2 * (GAP + 1) + 5);

    // Full FIFO: a symbol completing on the pop edge is accepted.
    bus.enable = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_sym(6'(33 + i));
    v = 6'd50;
    for (int i = 0; i < 5; i++) step(1, v[i], 0);
    bus.enable = 1'b1;
    step(1, v[5], 0);
    chk("full_push_pop_level", int'(bus.fifo_level), DEPTH);
    chk("full_push_pop_overflow", int'(bus.overflow), 0);
    idle((DEPTH + 1) * (GAP + 1) + 10);

    // Randomised traffic with occasional sync and enable toggles.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) bus.enable = ~bus.enable;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 39) == 0));
    end
    bus.enable = 1'b1;
    idle((DEPTH + 1) * (GAP + 1) + 20);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
